// File: rtl/mem_responder.sv
// Load/store responder in front of a word-wide SRAM that has no byte strobes.
// Sub-word stores use read-modify-write. Define MEM_RESP_ERR_EN to flag misaligned accesses.
package selectPkg;
    typedef enum logic [2:0] {SB = 3'd0, SH = 3'd1, SW = 3'd2, SBU = 3'd3, SHU = 3'd4} sel_type;
endpackage

module mem_responder #(
    parameter int          AW     = 10,
    parameter logic [31:0] RST_RD = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [2:0]    sel_type,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          rvalid,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic          ram_we,
    input  logic [31:0]   ram_rdata
);
    import selectPkg::*;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD_RSP = 2'd1;
    localparam logic [1:0] RMW      = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] lat_waddr;
    logic [1:0]    lat_lo;
    logic [2:0]    lat_sel;
    logic [15:0]   lat_wdata;
    logic          lat_err;
    logic [31:0]   rdata_q;
    logic [31:0]   ext;
    logic [31:0]   merged;
    logic          accept, is_byte, is_half, is_word, mis;
    logic [1:0]    lo;
    logic          unused;

    assign unused  = &{1'b0, addr[31:AW+2]};

    assign accept  = req && (state != RMW);
    assign is_byte = (sel_type == SB) || (sel_type == SBU);
    assign is_half = (sel_type == SH) || (sel_type == SHU);
    assign is_word = !(is_byte || is_half);
    // Lane offset forced down to the access alignment
    assign lo      = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);

`ifdef MEM_RESP_ERR_EN
    logic err_q;
    assign mis = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign err = err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept && mis;
    end
`else
    assign mis = 1'b0;
    assign err = 1'b0;
`endif

    assign ram_addr  = rst ? '0 : ((state == RMW) ? lat_waddr : addr[AW+1:2]);
    assign ram_we    = !rst && ((state == RMW) || (accept && we && is_word && !mis));
    assign ram_wdata = (state == RMW) ? merged : wdata;

    always_comb begin
        merged = ram_rdata;
        if (lat_sel == SB || lat_sel == SBU)
            merged[8*lat_lo +: 8] = lat_wdata[7:0];
        else if (lat_lo[1])
            merged[31:16] = lat_wdata;
        else
            merged[15:0] = lat_wdata;
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b   = ram_rdata[8*lat_lo +: 8];
        h   = lat_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        ext = ram_rdata;
        case (lat_sel)
            SB:      ext = {{24{b[7]}}, b};
            SBU:     ext = {24'h0, b};
            SH:      ext = {{16{h[15]}}, h};
            SHU:     ext = {16'h0, h};
            default: ext = ram_rdata;
        endcase
        if (lat_err) ext = RST_RD;
    end

    always_comb begin
        state_nxt = IDLE;
        if (accept) begin
            if (!we)                state_nxt = LOAD_RSP;
            else if (is_word || mis) state_nxt = IDLE;
            else                    state_nxt = RMW;
        end
    end

    assign rvalid = (state == LOAD_RSP);
    assign busy   = (state == RMW);
    assign rdata  = rvalid ? ext : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdata_q   <= RST_RD;
            lat_waddr <= '0;
            lat_lo    <= 2'b00;
            lat_sel   <= 3'd0;
            lat_wdata <= 16'h0;
            lat_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rvalid) rdata_q <= ext;
            if (accept) begin
                lat_waddr <= addr[AW+1:2];
                lat_lo    <= lo;
                lat_sel   <= sel_type;
                lat_wdata <= wdata[15:0];
                lat_err   <= mis;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus hand sequences for
// back-to-back loads, reset during RMW and misaligned accesses.
module tb_mem_responder;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2, SBU = 3'd3, SHU = 3'd4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [2:0]    sel_type;
    logic [31:0]   addr, wdata, rdata;
    logic          rvalid, busy, err;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          ram_we;

    logic [31:0] mem [0:(1<<AW)-1];
    int tests = 0;
    int failed = 0;

    mem_responder #(.AW(AW), .RST_RD(32'h0)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .sel_type(sel_type),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .busy(busy), .err(err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous read, read returns the old word on a write cycle
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        we;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:31];
    int   nv = 0;

    task automatic add(input logic w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e);
        vecs[nv].we = w; vecs[nv].sel = s; vecs[nv].addr = a;
        vecs[nv].wdata = d; vecs[nv].exp = e;
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        req = 1'b1; we = v.we; sel_type = v.sel; addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        req = 1'b0;
        if (!v.we) begin
            check($sformatf("v%0d rvalid", idx), {31'h0, rvalid}, 32'h1);
            check($sformatf("v%0d rdata", idx), rdata, v.exp);
        end else if (v.sel == SW) begin
            check($sformatf("v%0d sw busy", idx), {31'h0, busy}, 32'h0);
        end else begin
            check($sformatf("v%0d rmw busy", idx), {31'h0, busy}, 32'h1);
            @(posedge clk); #1;
            check($sformatf("v%0d rmw done", idx), {31'h0, busy}, 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        rst = 1'b1; req = 1'b0; we = 1'b0; sel_type = SW;
        addr = 32'h0000_0FFC; wdata = 32'h0;

        add(1, SW,  32'h10, 32'hDEADBEEF, 32'h0);
        add(0, SW,  32'h10, 32'h0,        32'hDEADBEEF);
        add(1, SW,  32'h10, 32'h80FF7F01, 32'h0);
        add(0, SB,  32'h13, 32'h0,        32'hFFFFFF80);
        add(0, SBU, 32'h13, 32'h0,        32'h00000080);
        add(0, SH,  32'h12, 32'h0,        32'hFFFF80FF);
        add(0, SHU, 32'h10, 32'h0,        32'h00007F01);
        add(0, SB,  32'h10, 32'h0,        32'h00000001);
        add(0, SBU, 32'h11, 32'h0,        32'h0000007F);
        add(0, SB,  32'h12, 32'h0,        32'hFFFFFFFF);
        add(1, SW,  32'h20, 32'h11223344, 32'h0);
        add(1, SB,  32'h21, 32'hFFFFFFAA, 32'h0);
        add(0, SW,  32'h20, 32'h0,        32'h1122AA44);
        add(1, SH,  32'h22, 32'h1234BEEF, 32'h0);
        add(0, SW,  32'h20, 32'h0,        32'hBEEFAA44);
        add(1, SBU, 32'h23, 32'h0000007F, 32'h0);
        add(0, SW,  32'h20, 32'h0,        32'h7FEFAA44);
        add(1, SHU, 32'h20, 32'h00001234, 32'h0);
        add(0, SHU, 32'h20, 32'h0,        32'h00001234);
        add(1, SW,  32'h1030, 32'hCAFEF00D, 32'h0);
        add(0, SW,  32'h30, 32'h0,        32'hCAFEF00D);
        add(1, SW,  32'h0,  32'h0BADF00D, 32'h0);
        add(1, SW,  32'h4,  32'h13579BDF, 32'h0);
        add(1, SW,  32'h8,  32'h2468ACE0, 32'h0);
        add(1, SW,  32'h40, 32'h55667788, 32'h0);

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("rst rdata",    rdata, 32'h0);
        check("rst rvalid",   {31'h0, rvalid}, 32'h0);
        check("rst busy",     {31'h0, busy}, 32'h0);
        check("rst err",      {31'h0, err}, 32'h0);
        check("rst ram_we",   {31'h0, ram_we}, 32'h0);
        check("rst ram_addr", {22'h0, ram_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) apply(vecs[i], i);

        // Back-to-back word loads
        @(negedge clk);
        req = 1'b1; we = 1'b0; sel_type = SW; addr = 32'h0;
        @(posedge clk); #1;
        check("b2b0 rvalid", {31'h0, rvalid}, 32'h1);
        check("b2b0 rdata", rdata, 32'h0BADF00D);
        addr = 32'h4;
        @(posedge clk); #1;
        check("b2b1 rvalid", {31'h0, rvalid}, 32'h1);
        check("b2b1 rdata", rdata, 32'h13579BDF);
        addr = 32'h8;
        @(posedge clk); #1;
        req = 1'b0;
        check("b2b2 rvalid", {31'h0, rvalid}, 32'h1);
        check("b2b2 rdata", rdata, 32'h2468ACE0);
        @(posedge clk); #1;
        check("hold rvalid", {31'h0, rvalid}, 32'h0);
        check("hold rdata", rdata, 32'h2468ACE0);

        // Reset landing in the RMW cycle aborts the write
        @(negedge clk);
        req = 1'b1; we = 1'b1; sel_type = SB; addr = 32'h40; wdata = 32'h11;
        @(posedge clk); #1;
        req = 1'b0;
        check("rstrmw busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstrmw ram_we", {31'h0, ram_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstrmw busy after", {31'h0, busy}, 32'h0);
        begin
            vec_t v;
            v.we = 0; v.sel = SW; v.addr = 32'h40; v.wdata = 0; v.exp = 32'h55667788;
            apply(v, 100);
        end

`ifdef MEM_RESP_ERR_EN
        @(negedge clk);
        req = 1'b1; we = 1'b0; sel_type = SW; addr = 32'h2;
        @(posedge clk); #1;
        req = 1'b0;
        check("mis lw rvalid", {31'h0, rvalid}, 32'h1);
        check("mis lw err", {31'h0, err}, 32'h1);
        check("mis lw rdata", rdata, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; sel_type = SH; addr = 32'h1; wdata = 32'h5555;
        #1;
        check("mis sh ram_we", {31'h0, ram_we}, 32'h0);
        @(posedge clk); #1;
        req = 1'b0;
        check("mis sh err", {31'h0, err}, 32'h1);
        check("mis sh busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        check("mis sh err clr", {31'h0, err}, 32'h0);
        begin
            vec_t v;
            v.we = 0; v.sel = SW; v.addr = 32'h0; v.wdata = 0; v.exp = 32'h0BADF00D;
            apply(v, 101);
        end
`else
        begin
            vec_t v;
            v.we = 0; v.sel = SW; v.addr = 32'h2; v.wdata = 0; v.exp = 32'h0BADF00D;
            apply(v, 101);
            check("mask err", {31'h0, err}, 32'h0);
            v.sel = SHU; v.addr = 32'h7; v.exp = 32'h00001357;
            apply(v, 102);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
